// File: rtl/cla_digit_serial_adder_pkg.sv
// Shared definitions for the digit-serial adder: FSM state encoding, slice
// width and helpers that derive the nibble count and index width.
package cla_digit_serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam int SLICE_W = 4;

    function automatic int nib_count(input int width);
        return width / SLICE_W;
    endfunction

    function automatic int idx_width(input int width);
        return (nib_count(width) > 1) ? $clog2(nib_count(width)) : 1;
    endfunction

endpackage

// File: rtl/cla_digit_serial_adder_cla4.sv
// 4-bit carry-lookahead slice: all internal carries are computed directly
// from the generate/propagate terms, plus group P/G for cascading.
module carry_lookahead_adder_4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout,
    output logic       pg,
    output logic       gg
);

    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] c;

    // Lookahead carries, sum bits and group propagate/generate.
    always_comb begin
        p    = a ^ b;
        g    = a & b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        pg   = &p;
        gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        cout = gg | (pg & cin);
        sum  = p ^ c;
    end

endmodule

// File: rtl/cla_digit_serial_adder.sv
// Digit-serial WIDTH-bit adder: one nibble per clock through a single 4-bit
// CLA slice, LS nibble first, with valid/ready handshakes on both sides.
module cla_digit_serial_adder
    import cla_digit_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             busy
);

    localparam int NIB   = nib_count(WIDTH);
    localparam int IDX_W = idx_width(WIDTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

    state_t                  state;
    state_t                  state_nx;
    logic [IDX_W-1:0]        idx;
    logic signed [WIDTH-1:0] a_r;
    logic signed [WIDTH-1:0] b_r;
    logic signed [WIDTH-1:0] sum_r;
    logic                    carry_r;
    logic                    accept;
    logic [3:0]              slice_a;
    logic [3:0]              slice_b;
    logic [3:0]              slice_sum;
    logic                    slice_cout;
    logic                    unused_pg;
    logic                    unused_gg;

    // Signed overflow: operands agree in sign but the result does not.
    function automatic logic add_ovf(input logic signed [WIDTH-1:0] a,
                                     input logic signed [WIDTH-1:0] b,
                                     input logic signed [WIDTH-1:0] s);
        return ((a < 0) == (b < 0)) && ((s < 0) != (a < 0));
    endfunction

    // Handshake/status flags come straight from the state register.
    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state == ST_RUN) || (state == ST_DONE);
    assign accept    = in_valid && in_ready;

    // Data registers are gated here so nothing partial is ever visible.
    assign out_sum  = out_valid ? sum_r : '0;
    assign out_cout = out_valid & carry_r;
    assign out_ovf  = out_valid & add_ovf(a_r, b_r, sum_r);

    assign slice_a = a_r[SLICE_W*idx +: SLICE_W];
    assign slice_b = b_r[SLICE_W*idx +: SLICE_W];

    carry_lookahead_adder_4 u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_r),
        .sum  (slice_sum),
        .cout (slice_cout),
        .pg   (unused_pg),
        .gg   (unused_gg)
    );

    // State register; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode; the unused encoding falls back to IDLE.
    always_comb begin
        state_nx = ST_IDLE;
        case (state)
            ST_IDLE: state_nx = accept ? ST_RUN : ST_IDLE;
            ST_RUN:  state_nx = (idx == IDX_LAST) ? ST_DONE : ST_RUN;
            ST_DONE: state_nx = out_ready ? ST_IDLE : ST_DONE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Nibble index: cleared on accept, advances once per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (accept) begin
            idx <= '0;
        end else if (state == ST_RUN) begin
            idx <= idx + 1'b1;
        end
    end

    // Operand capture and per-nibble sum/carry accumulation (no reset needed:
    // outputs are masked by state and everything is loaded on accept).
    always_ff @(posedge clk) begin
        if (accept) begin
            a_r     <= in_a;
            b_r     <= in_b;
            carry_r <= in_cin;
            sum_r   <= '0;
        end else if (state == ST_RUN) begin
            sum_r[SLICE_W*idx +: SLICE_W] <= slice_sum;
            carry_r                       <= slice_cout;
        end
    end

endmodule

// File: tb/tb_cla_digit_serial_adder.sv
// Directed self-checking bench for cla_digit_serial_adder at WIDTH=16.
module tb_cla_digit_serial_adder;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic             busy;

    int n_checks;
    int n_pass;

    cla_digit_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp_v);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands, wait for the result, check it, then consume it.
    task automatic start_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic cin);
        int waited;
        waited = 0;
        while (!in_ready && waited < 20) begin
            tick();
            waited++;
        end
        check({tag, "_ready"}, in_ready, 1);
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag, input logic [15:0] exp_sum,
                               input logic exp_cout, input logic exp_ovf);
        int edges;
        edges = 0;
        while (!out_valid && edges < 20) begin
            tick();
            edges++;
        end
        check({tag, "_lat"}, edges, 4);
        check({tag, "_sum"}, out_sum, exp_sum);
        check({tag, "_cout"}, out_cout, exp_cout);
        check({tag, "_ovf"}, out_ovf, exp_ovf);
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_vld_clr"}, out_valid, 0);
        check({tag, "_rdy_back"}, in_ready, 1);
    endtask

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic [15:0] exp_sum,
                          input logic exp_cout, input logic exp_ovf);
        start_op(tag, a, b, cin);
        wait_result(tag, exp_sum, exp_cout, exp_ovf);
        consume(tag);
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sum", out_sum, 0);
        check("rst_cout", out_cout, 0);
        check("rst_ovf", out_ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rst_in_ready", in_ready, 1);

        run_op("t1", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        run_op("t2", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("t3a", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("t3b", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        run_op("t4", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        run_op("cin_mid", 16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0, 1'b0);

        // Backpressure: result must hold while new operands are ignored.
        start_op("bp", 16'h1234, 16'h4321, 1'b0);
        wait_result("bp", 16'h5555, 1'b0, 1'b0);
        in_a     = 16'h1111;
        in_b     = 16'h2222;
        in_cin   = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", out_valid, 1);
            check("bp_sum", out_sum, 16'h5555);
            check("bp_cout", out_cout, 0);
            check("bp_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        consume("bp");
        tick();
        check("bp_no_capture", busy, 0);

        // Reset in the middle of RUN (idx=2).
        start_op("mid", 16'hFFFF, 16'h0001, 1'b0);
        tick();
        tick();
        check("mid_busy_pre", busy, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_busy", busy, 0);
        check("mid_valid", out_valid, 0);
        check("mid_sum", out_sum, 0);
        check("mid_cout", out_cout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("mid_in_ready", in_ready, 1);
        run_op("post", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
